// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: op and state encodings
// plus the iteration-counter width helper.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  function automatic int cntWidth(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// One iteration of the unsigned datapath: a shift-add multiply step or a restoring
// divide step. Divide support is compiled in only when MULDIV_DIV_EN is defined.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               isDiv,
  input  logic [2*WIDTH-1:0] accIn,
  input  logic [WIDTH:0]     remIn,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] accOut,
  output logic [WIDTH:0]     remOut
);

  logic [WIDTH:0] addSum;

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;
  logic           unusedRemMsb;

  // The partial remainder stays below the divisor, so its top bit never shifts out.
  assign unusedRemMsb = remIn[WIDTH];

  always_comb begin
    addSum  = {1'b0, accIn[2*WIDTH-1:WIDTH]} + {1'b0, (accIn[0] ? operand : '0)};
    shifted = {remIn[WIDTH-1:0], accIn[WIDTH-1]};
    diff    = shifted - {1'b0, operand};
    fits    = (shifted >= {1'b0, operand});
    if (isDiv) begin
      accOut = {accIn[2*WIDTH-1:WIDTH], accIn[WIDTH-2:0], fits};
      remOut = fits ? diff : shifted;
    end else begin
      accOut = {addSum, accIn[WIDTH-1:1]};
      remOut = remIn;
    end
  end
`else
  logic unusedDiv;
  assign unusedDiv = isDiv;

  always_comb begin
    addSum = {1'b0, accIn[2*WIDTH-1:WIDTH]} + {1'b0, (accIn[0] ? operand : '0)};
    accOut = {addSum, accIn[WIDTH-1:1]};
    remOut = remIn;
  end
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers and an EX-stage
// stall request. Define MULDIV_DIV_EN to include DIV/DIVU; otherwise only MULT/MULTU run.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             mf_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             stall,
  output logic [1:0]       dbgState
);

  localparam int CW = cntWidth(WIDTH);

`ifdef MULDIV_DIV_EN
  localparam logic DIV_EN = 1'b1;
`else
  localparam logic DIV_EN = 1'b0;
`endif

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : gBadWidth
    $error("muldiv_unit: WIDTH must be a power of two and at least 4");
  end

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] accNext;
  logic [WIDTH:0]     rem;
  logic [WIDTH:0]     remNext;
  logic [WIDTH-1:0]   operand;
  logic               signA;
  logic               signB;
  logic               isDiv;
  logic               bZero;

  logic               opSigned;
  logic               aNeg;
  logic               bNeg;
  logic               opIsDiv;
  logic               accept;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotS;
  logic [WIDTH-1:0]   remS;
  logic [WIDTH-1:0]   resHi;
  logic [WIDTH-1:0]   resLo;
  logic               unusedRemMsb;

  assign unusedRemMsb = rem[WIDTH];

  always_comb begin
    opSigned = ~op[0];
    aNeg     = opSigned & a[WIDTH-1];
    bNeg     = opSigned & b[WIDTH-1];
    absA     = aNeg ? -a : a;
    absB     = bNeg ? -b : b;
    opIsDiv  = op[1] & DIV_EN;
    // Divides are refused outright when the divide datapath is not built.
    accept   = (state == S_IDLE) & start & (DIV_EN | ~op[1]);
  end

  muldiv_core #(.WIDTH(WIDTH)) uCore (
    .isDiv   (isDiv),
    .accIn   (acc),
    .remIn   (rem),
    .operand (operand),
    .accOut  (accNext),
    .remOut  (remNext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      rem     <= '0;
      operand <= '0;
      signA   <= 1'b0;
      signB   <= 1'b0;
      isDiv   <= 1'b0;
      bZero   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state   <= S_RUN;
            cnt     <= '0;
            rem     <= '0;
            // Multiply shifts the multiplier out of the low half; divide shifts the dividend.
            acc     <= {{WIDTH{1'b0}}, (opIsDiv ? absA : absB)};
            operand <= opIsDiv ? absB : absA;
            signA   <= aNeg;
            signB   <= bNeg;
            isDiv   <= opIsDiv;
            bZero   <= (b == '0);
          end
        end
        S_RUN: begin
          acc <= accNext;
          rem <= remNext;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= S_FINISH;
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    product = (signA ^ signB) ? -acc : acc;
    quotS   = (signA ^ signB) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    remS    = signA ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    if (isDiv) begin
      resHi = remS;
      resLo = bZero ? '1 : quotS;
    end else begin
      resHi = product[2*WIDTH-1:WIDTH];
      resLo = product[WIDTH-1:0];
    end
  end

  // mthi/mtlo only land in IDLE, and any start request in that cycle takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == S_FINISH);
      if (state == S_FINISH) begin
        hi <= resHi;
        lo <= resLo;
      end else if (state == S_IDLE && !start) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

`ifdef MULDIV_DIV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_by_zero <= 1'b0;
    end else if (accept) begin
      div_by_zero <= 1'b0;
    end else if (state == S_FINISH && isDiv && bZero) begin
      div_by_zero <= 1'b1;
    end
  end
`else
  assign div_by_zero = 1'b0;
`endif

  assign busy     = (state == S_RUN) || (state == S_FINISH);
  assign stall    = busy & mf_req;
  assign dbgState = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32): results are predicted by a behavioural
// model into a queue at launch and compared on the done pulse.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         mf_req;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic         stall;
  logic [1:0]   dbgState;

  int checks = 0;
  int failures = 0;
  logic [2*W-1:0] exp_q[$];

  logic [W-1:0] hiSave;
  logic [W-1:0] loSave;
  int           bad;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .mf_req      (mf_req),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .stall       (stall),
    .dbgState    (dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sp;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    case (o)
      OP_MULT: begin
        sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        return sp;
      end
      OP_MULTU: return {32'b0, x} * {32'b0, y};
      OP_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sq = $signed(x) / $signed(y);
        sr = $signed(x) % $signed(y);
        return {sr, sq};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // driver: called at a negedge, returns just after the sampling edge
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    exp_q.push_back(model(o, x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_result(input string tag);
    logic [63:0] e;
    check({tag, "_sb"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
      check({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
    end
  endtask

  // Runs one op and checks latency plus the busy/stall/HI/LO profile of every cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input string tag, input bit mf, input bit pokeHi, input bit pokeStart);
    logic [31:0] hiBefore;
    logic [31:0] loBefore;
    int n;
    int nbad;
    hiBefore = hi;
    loBefore = lo;
    mf_req = mf;
    launch(o, x, y);
    n = 0;
    nbad = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      hi_we = pokeHi && (n == 5);
      lo_we = pokeHi && (n == 5);
      wdata = 32'hDEAD_BEEF;
      start = pokeStart && (n == 10);
      if (pokeStart && n == 10) begin
        op = OP_MULTU;
        a = 32'd3;
        b = 32'd5;
      end
      if (done) break;
      if (busy !== 1'b1) nbad++;
      if (stall !== mf) nbad++;
      if (hi !== hiBefore || lo !== loBefore) nbad++;
      if (n == 1 && div_by_zero !== 1'b0) nbad++;
    end
    check({tag, "_latency"}, 64'(n), 64'd34);
    check({tag, "_profile"}, 64'(nbad), 64'd0);
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    check({tag, "_stall_done"}, 64'(stall), 64'd0);
    check_result(tag);
    mf_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    mf_req = 1'b1;

    // reset state
    #3;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mf_req = 1'b0;
    @(negedge clk);
    check("idle_state", 64'(dbgState), 64'(S_IDLE));

    // mthi / mtlo in IDLE
    hi_we = 1'b1;
    wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b1;
    wdata = 32'h9ABC_DEF0;
    @(negedge clk);
    lo_we = 1'b0;
    check("mthi", 64'(hi), 64'h1234_5678);
    check("mtlo", 64'(lo), 64'h9ABC_DEF0);

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg", 1'b0, 1'b0, 1'b0);
    // launched in the done cycle, with mf_req held high
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max_b2b", 1'b1, 1'b0, 1'b0);
    run_op(OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, "hiwe_run", 1'b0, 1'b1, 1'b0);
    run_op(OP_MULTU, 32'd1000, 32'd2000, "start_run", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("start_run_no_queue", 64'(busy), 64'd0);

    // start and mthi/mtlo in the same IDLE cycle: the write is dropped
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h5555_AAAA;
    run_op(OP_MULT, 32'd12345, 32'hFFFF_FD5A, "start_wins", 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      run_op(OP_MULT, $urandom, $urandom, "rnd_mult", 1'b0, 1'b0, 1'b0);
      run_op(OP_MULTU, $urandom, $urandom_range(0, 65535), "rnd_multu", 1'b0, 1'b0, 1'b0);
    end

`ifdef MULDIV_DIV_EN
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg", 1'b0, 1'b0, 1'b0);
    check("div_neg_dbz", 64'(div_by_zero), 64'd0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0, 1'b0, 1'b0);
    run_op(OP_DIVU, 32'd5, 32'd0, "divu_zero", 1'b0, 1'b0, 1'b0);
    check("divu_zero_dbz", 64'(div_by_zero), 64'd1);
    run_op(OP_DIV, 32'hFFFF_FF00, 32'd0, "div_zero_neg", 1'b0, 1'b0, 1'b0);
    check("div_zero_neg_dbz", 64'(div_by_zero), 64'd1);
    run_op(OP_DIVU, 32'd100, 32'd7, "divu_after_zero", 1'b0, 1'b0, 1'b0);
    check("dbz_cleared", 64'(div_by_zero), 64'd0);
    for (int i = 0; i < 3; i++) begin
      run_op(OP_DIV, $urandom, $urandom, "rnd_div", 1'b0, 1'b0, 1'b0);
      run_op(OP_DIVU, $urandom, $urandom_range(1, 1000), "rnd_divu", 1'b0, 1'b0, 1'b0);
    end
`else
    hiSave = hi;
    loSave = lo;
    op = OP_DIV;
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("div_off_idle", 64'(bad), 64'd0);
    check("div_off_hi", 64'(hi), 64'(hiSave));
    check("div_off_lo", 64'(lo), 64'(loSave));
    check("div_off_dbz", 64'(div_by_zero), 64'd0);
`endif

    // reset in the middle of an operation
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hCAFE_0001;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    launch(OP_MULTU, 32'd9, 32'd9);
    exp_q.delete();
    repeat (10) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_state", 64'(dbgState), 64'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("mid_rst_no_done", 64'(bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
